// File: rtl/neuron_stream_loader.sv
// Byte-stream loader for the neuron datapath: packs inputs/weights, starts the neuron, returns its result.
// Optional NEURON_LOADER_WEIGHT_HOLD_EN keeps weights across runs until a timeout forces a reload.
module neuron_stream_loader #(
  parameter int INPUT_COUNT = 8,
  parameter int TIMEOUT     = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_valid,
  input  logic [7:0]               s_data,
  output logic                     s_ready,
  output logic [INPUT_COUNT*8-1:0] neuron_inputs,
  output logic [INPUT_COUNT*8-1:0] neuron_weights,
  output logic                     neuron_start,
  input  logic                     neuron_ready,
  input  logic [7:0]               neuron_out,
  output logic                     m_valid,
  output logic [7:0]               m_data,
  input  logic                     m_ready,
  output logic                     timeout_err,
  output logic [2:0]               state_dbg
);

  // Handshakes: a beat transfers on a rising edge where valid && ready are both high;
  // valid, once raised by this block, stays high with stable data until that edge.

  typedef enum logic [2:0] {
    ST_LOAD  = 3'd0,
    ST_START = 3'd1,
    ST_GUARD = 3'd2,
    ST_WAIT  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam int CW = $clog2(2*INPUT_COUNT+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam logic [CW-1:0] LAST_FULL = CW'(2*INPUT_COUNT-1);
  localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT-1);

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [TW-1:0]   wait_cnt;
  logic [CW-1:0]   last_beat;

`ifdef NEURON_LOADER_WEIGHT_HOLD_EN
  localparam logic [CW-1:0] LAST_IN = CW'(INPUT_COUNT-1);
  logic weights_held;
  assign last_beat = weights_held ? LAST_IN : LAST_FULL;
`else
  assign last_beat = LAST_FULL;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_LOAD;
      cnt            <= '0;
      wait_cnt       <= '0;
      s_ready        <= 1'b0;
      neuron_inputs  <= '0;
      neuron_weights <= '0;
      neuron_start   <= 1'b0;
      m_valid        <= 1'b0;
      m_data         <= '0;
      timeout_err    <= 1'b0;
`ifdef NEURON_LOADER_WEIGHT_HOLD_EN
      weights_held   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_LOAD: begin
          s_ready <= 1'b1;
          if (s_valid && s_ready) begin
            for (int k = 0; k < INPUT_COUNT; k++) begin
              if (cnt == CW'(k))
                neuron_inputs[8*k +: 8] <= s_data;
              if (cnt == CW'(k + INPUT_COUNT))
                neuron_weights[8*k +: 8] <= s_data;
            end
            if (cnt == last_beat) begin
              cnt          <= '0;
              s_ready      <= 1'b0;
              neuron_start <= 1'b1;
              state        <= ST_START;
`ifdef NEURON_LOADER_WEIGHT_HOLD_EN
              weights_held <= 1'b1;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_START: begin
          neuron_start <= 1'b0;
          wait_cnt     <= '0;
          state        <= ST_GUARD;
        end
        // Ready left high by the previous evaluation must not be taken as this run's result.
        ST_GUARD: state <= ST_WAIT;
        ST_WAIT: begin
          if (neuron_ready) begin
            m_data  <= neuron_out;
            m_valid <= 1'b1;
            state   <= ST_OUT;
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_err <= 1'b1;
            m_data      <= '0;
            m_valid     <= 1'b1;
            state       <= ST_OUT;
`ifdef NEURON_LOADER_WEIGHT_HOLD_EN
            weights_held <= 1'b0;
`endif
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_OUT: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule
